// File: rtl/fadd_stream_master_if.sv
// Handshake bundle between the float-adder stream master and its environment:
// upstream operand port, adder A/B/result channels, downstream result port and status.
interface fadd_stream_master_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
);
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  logic              m_axis_a_tvalid;
  logic              m_axis_a_tready;
  logic [DATA_W-1:0] m_axis_a_tdata;
  logic              m_axis_b_tvalid;
  logic              m_axis_b_tready;
  logic [DATA_W-1:0] m_axis_b_tdata;

  logic              s_axis_result_tvalid;
  logic              s_axis_result_tready;
  logic [DATA_W-1:0] s_axis_result_tdata;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;

  logic [CNT_W-1:0]  inflight;
  logic              err_unexpected;

  modport master (
    input  op_valid, op_a, op_b,
    output op_ready,
    output m_axis_a_tvalid, m_axis_a_tdata,
    input  m_axis_a_tready,
    output m_axis_b_tvalid, m_axis_b_tdata,
    input  m_axis_b_tready,
    input  s_axis_result_tvalid, s_axis_result_tdata,
    output s_axis_result_tready,
    output res_valid, res_data,
    input  res_ready,
    output inflight, err_unexpected
  );

  modport slave (
    output op_valid, op_a, op_b,
    input  op_ready,
    input  m_axis_a_tvalid, m_axis_a_tdata,
    output m_axis_a_tready,
    input  m_axis_b_tvalid, m_axis_b_tdata,
    output m_axis_b_tready,
    output s_axis_result_tvalid, s_axis_result_tdata,
    input  s_axis_result_tready,
    input  res_valid, res_data,
    output res_ready,
    input  inflight, err_unexpected
  );
endinterface

// File: rtl/fadd_stream_master.sv
// Drives the A/B operand channels of an AXI-Stream float adder and buffers its results.
// Credits are reserved per operation so the adder result channel never sees back-pressure.
module fadd_stream_master #(
  parameter int DATA_W    = 32,
  parameter int RES_DEPTH = 16,
  parameter int CNT_W     = $clog2(RES_DEPTH) + 1
) (
  input logic                  aclk,
  input logic                  aresetn,
  fadd_stream_master_if.master bus
);
  localparam int               PTR_W = $clog2(RES_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(RES_DEPTH);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic              a_pend;
  logic              b_pend;
  logic [DATA_W-1:0] a_data;
  logic [DATA_W-1:0] b_data;
  logic [CNT_W-1:0]  reserved;
  logic [CNT_W-1:0]  inflight_q;
  logic              err_q;
  logic [DATA_W-1:0] mem [RES_DEPTH];
  logic [CNT_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  rd_ptr;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  logic op_ready_c;
  logic op_hs;
  logic a_hs;
  logic b_hs;
  logic accept_res;
  logic stray_res;
  logic res_hs;
  logic mem_empty;
  logic load_out;

  assign a_hs       = a_pend && bus.m_axis_a_tready;
  assign b_hs       = b_pend && bus.m_axis_b_tready;
  assign op_ready_c = aresetn && (!a_pend || bus.m_axis_a_tready)
                      && (!b_pend || bus.m_axis_b_tready) && (reserved < DEPTH);
  assign op_hs      = bus.op_valid && op_ready_c;
  assign accept_res = aresetn && bus.s_axis_result_tvalid && (inflight_q != '0);
  assign stray_res  = aresetn && bus.s_axis_result_tvalid && (inflight_q == '0);
  assign res_hs     = out_valid && bus.res_ready;
  assign mem_empty  = (wr_ptr == rd_ptr);
  // The output register refills whenever it is empty or being drained this cycle.
  assign load_out   = !mem_empty && (!out_valid || bus.res_ready);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      a_pend <= 1'b0;
      b_pend <= 1'b0;
      a_data <= '0;
      b_data <= '0;
    end else begin
      if (op_hs) begin
        a_pend <= 1'b1;
        a_data <= bus.op_a;
      end else if (a_hs) begin
        a_pend <= 1'b0;
      end
      if (op_hs) begin
        b_pend <= 1'b1;
        b_data <= bus.op_b;
      end else if (b_hs) begin
        b_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      reserved   <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case ({op_hs, res_hs})
        2'b10:   reserved <= reserved + ONE;
        2'b01:   reserved <= reserved - ONE;
        default: reserved <= reserved;
      endcase
      case ({op_hs, accept_res})
        2'b10:   inflight_q <= inflight_q + ONE;
        2'b01:   inflight_q <= inflight_q - ONE;
        default: inflight_q <= inflight_q;
      endcase
      if (stray_res) begin
        err_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset: only pointer-qualified entries are ever read.
  always_ff @(posedge aclk) begin
    if (accept_res) begin
      mem[wr_ptr[PTR_W-1:0]] <= bus.s_axis_result_tdata;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (accept_res) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (load_out) begin
        out_valid <= 1'b1;
        out_data  <= mem[rd_ptr[PTR_W-1:0]];
        rd_ptr    <= rd_ptr + ONE;
      end else if (bus.res_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.op_ready             = op_ready_c;
  assign bus.m_axis_a_tvalid      = a_pend;
  assign bus.m_axis_a_tdata       = a_data;
  assign bus.m_axis_b_tvalid      = b_pend;
  assign bus.m_axis_b_tdata       = b_data;
  assign bus.s_axis_result_tready = aresetn;
  assign bus.res_valid            = out_valid;
  assign bus.res_data             = out_data;
  assign bus.inflight             = inflight_q;
  assign bus.err_unexpected       = err_q;
endmodule

// File: tb/tb_fadd_stream_master.sv
// Randomized scoreboard bench for fadd_stream_master with a fixed-latency adder model.
// Operands are small integers encoded as floats so sums are exact.
module tb_fadd_stream_master;
  localparam int DATA_W    = 32;
  localparam int RES_DEPTH = 16;
  localparam int CNT_W     = 5;
  localparam int ADD_LAT   = 3;

  typedef struct {
    int          due;
    logic [31:0] data;
  } pipe_t;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  fadd_stream_master_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  fadd_stream_master #(.DATA_W(DATA_W), .RES_DEPTH(RES_DEPTH), .CNT_W(CNT_W)) dut (
    .aclk    (clk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];
  logic [31:0] qa [$];
  logic [31:0] qb [$];
  pipe_t       pipe [$];

  int          m_reserved = 0;
  int          m_inflight = 0;
  bit          m_err = 0;
  bit          m_a_pend = 0;
  bit          m_b_pend = 0;
  logic [31:0] m_a_data = '0;
  logic [31:0] m_b_data = '0;
  bit          prev_res_stall = 0;
  logic [31:0] prev_res_data = '0;
  logic [31:0] last_res = '0;
  int          accepted_cnt = 0;
  int          res_seen = 0;
  int          cycle = 0;

  bit          tk_a = 0, tk_b = 0, tk_r = 0;
  logic [31:0] tk_a_data = '0, tk_b_data = '0;
  bit          stray_req = 0, stray_active = 0, rst_edge = 0;
  bit          op_hs, a_hs, b_hs, r_hs, res_hs, exp_ready;

  function automatic logic [31:0] to_f(int unsigned n);
    int          e;
    logic [31:0] m;
    if (n == 0) return 32'd0;
    e = 31;
    while (n[e] == 1'b0) e--;
    m = n << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  function automatic int unsigned from_f(logic [31:0] f);
    int          e;
    logic [31:0] m;
    if (f[30:0] == 31'd0) return 0;
    e = int'(f[30:23]) - 127;
    m = {8'd0, 1'b1, f[22:0]};
    if (e < 0) return 0;
    if (e > 23) return m << ((e > 31 ? 31 : e) - 23);
    return m >> (23 - e);
  endfunction

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Adder model: pairs A/B in arrival order, returns the sum ADD_LAT cycles later.
  always @(posedge clk) begin
    rst_edge = !aresetn;
    #1;
    cycle++;
    if (rst_edge) begin
      qa.delete();
      qb.delete();
      pipe.delete();
      stray_active = 0;
    end else begin
      if (tk_a) qa.push_back(tk_a_data);
      if (tk_b) qb.push_back(tk_b_data);
      if (tk_r) begin
        if (stray_active) stray_active = 0;
        else if (pipe.size() > 0) void'(pipe.pop_front());
      end
      if (stray_req && !stray_active) begin
        stray_active = 1;
        stray_req    = 0;
      end
      while (qa.size() > 0 && qb.size() > 0) begin
        pipe_t p;
        p.due  = cycle + ADD_LAT;
        p.data = to_f(from_f(qa.pop_front()) + from_f(qb.pop_front()));
        pipe.push_back(p);
      end
    end
    if (stray_active) begin
      bus.s_axis_result_tvalid = 1'b1;
      bus.s_axis_result_tdata  = 32'h12345678;
    end else if (pipe.size() > 0 && pipe[0].due <= cycle) begin
      bus.s_axis_result_tvalid = 1'b1;
      bus.s_axis_result_tdata  = pipe[0].data;
    end else begin
      bus.s_axis_result_tvalid = 1'b0;
      bus.s_axis_result_tdata  = '0;
    end
  end

  // Monitor: checks every cycle against the model, then advances it by this cycle's handshakes.
  always @(negedge clk) begin
    if (!aresetn) begin
      exp_q.delete();
      m_reserved = 0; m_inflight = 0; m_err = 0;
      m_a_pend = 0; m_b_pend = 0; prev_res_stall = 0;
      tk_a = 0; tk_b = 0; tk_r = 0;
    end else begin
      exp_ready = (!m_a_pend || bus.m_axis_a_tready) && (!m_b_pend || bus.m_axis_b_tready)
                  && (m_reserved < RES_DEPTH);
      check_output("op_ready", 32'(bus.op_ready), 32'(exp_ready));
      check_output("a_tvalid", 32'(bus.m_axis_a_tvalid), 32'(m_a_pend));
      check_output("b_tvalid", 32'(bus.m_axis_b_tvalid), 32'(m_b_pend));
      if (m_a_pend) check_output("a_tdata", bus.m_axis_a_tdata, m_a_data);
      if (m_b_pend) check_output("b_tdata", bus.m_axis_b_tdata, m_b_data);
      check_output("s_tready", 32'(bus.s_axis_result_tready), 32'd1);
      check_output("inflight", 32'(bus.inflight), 32'(m_inflight));
      check_output("err_unexpected", 32'(bus.err_unexpected), 32'(m_err));
      if (prev_res_stall) begin
        check_output("res_hold_valid", 32'(bus.res_valid), 32'd1);
        check_output("res_hold_data", bus.res_data, prev_res_data);
      end

      op_hs  = bus.op_valid && bus.op_ready;
      a_hs   = bus.m_axis_a_tvalid && bus.m_axis_a_tready;
      b_hs   = bus.m_axis_b_tvalid && bus.m_axis_b_tready;
      r_hs   = bus.s_axis_result_tvalid && bus.s_axis_result_tready;
      res_hs = bus.res_valid && bus.res_ready;

      if (res_hs) begin
        res_seen++;
        last_res = bus.res_data;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result: got 0x%0h, expected no result", bus.res_data);
        end else begin
          check_output("res_data", bus.res_data, exp_q.pop_front());
        end
      end
      if (op_hs) begin
        exp_q.push_back(to_f(from_f(bus.op_a) + from_f(bus.op_b)));
        accepted_cnt++;
        m_a_pend = 1; m_a_data = bus.op_a;
        m_b_pend = 1; m_b_data = bus.op_b;
      end else begin
        if (a_hs) m_a_pend = 0;
        if (b_hs) m_b_pend = 0;
      end
      m_reserved = m_reserved + int'(op_hs) - int'(res_hs);
      if (r_hs && m_inflight == 0) m_err = 1;
      m_inflight = m_inflight + int'(op_hs) - int'(r_hs && m_inflight > 0);

      prev_res_stall = bus.res_valid && !bus.res_ready;
      prev_res_data  = bus.res_data;
      tk_a = a_hs; tk_a_data = bus.m_axis_a_tdata;
      tk_b = b_hs; tk_b_data = bus.m_axis_b_tdata;
      tk_r = r_hs;
    end
  end

  task automatic wait_cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(int unsigned a, int unsigned b, int max_wait, output bit acc);
    bus.op_valid = 1'b1;
    bus.op_a     = to_f(a);
    bus.op_b     = to_f(b);
    acc = 0;
    for (int i = 0; i < max_wait && !acc; i++) begin
      @(negedge clk);
      acc = bus.op_ready;
      @(posedge clk);
      #1;
    end
    bus.op_valid = 1'b0;
  endtask

  task automatic check_reset_state();
    check_output("rst_op_ready", 32'(bus.op_ready), 32'd0);
    check_output("rst_a_tvalid", 32'(bus.m_axis_a_tvalid), 32'd0);
    check_output("rst_b_tvalid", 32'(bus.m_axis_b_tvalid), 32'd0);
    check_output("rst_a_tdata", bus.m_axis_a_tdata, 32'd0);
    check_output("rst_b_tdata", bus.m_axis_b_tdata, 32'd0);
    check_output("rst_s_tready", 32'(bus.s_axis_result_tready), 32'd0);
    check_output("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check_output("rst_res_data", bus.res_data, 32'd0);
    check_output("rst_inflight", 32'(bus.inflight), 32'd0);
    check_output("rst_err", 32'(bus.err_unexpected), 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    bus.op_valid        = 1'b0;
    bus.m_axis_a_tready = 1'b1;
    bus.m_axis_b_tready = 1'b1;
    bus.res_ready       = 1'b1;
    while (n < 300 && (exp_q.size() != 0 || m_inflight != 0 || pipe.size() != 0)) begin
      wait_cycles(1);
      n++;
    end
    wait_cycles(2);
    check_output("drain_pending", 32'(exp_q.size()), 32'd0);
    check_output("drain_inflight", 32'(bus.inflight), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit acc;
    bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0;
    bus.m_axis_a_tready = 1'b1; bus.m_axis_b_tready = 1'b1;
    bus.s_axis_result_tvalid = 1'b0; bus.s_axis_result_tdata = '0;
    bus.res_ready = 1'b1;

    wait_cycles(3);
    check_reset_state();
    aresetn = 1'b1;
    wait_cycles(1);

    $display("[TB] single operation");
    apply_stimulus(1, 2, 5, acc);
    check_output("single_accept", 32'(acc), 32'd1);
    drain();
    check_output("single_result", last_res, 32'h40400000);

    $display("[TB] streaming");
    for (int i = 1; i <= 32; i++) begin
      apply_stimulus(i, i, 1, acc);
      check_output("stream_ready", 32'(acc), 32'd1);
    end
    drain();
    check_output("stream_last", last_res, to_f(64));

    $display("[TB] credit limit");
    bus.res_ready = 1'b0;
    accepted_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      apply_stimulus($urandom_range(1, 1000), $urandom_range(1, 1000), 1, acc);
    end
    wait_cycles(10);
    check_output("credit_accepted", 32'(accepted_cnt), 32'd16);
    bus.op_valid = 1'b1;
    bus.op_a = to_f(7);
    bus.op_b = to_f(9);
    @(negedge clk);
    check_output("credit_full_ready", 32'(bus.op_ready), 32'd0);
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    wait_cycles(1);
    bus.res_ready = 1'b0;
    wait_cycles(6);
    bus.op_valid = 1'b0;
    check_output("credit_one_more", 32'(accepted_cnt), 32'd17);
    drain();

    $display("[TB] skewed channels");
    bus.m_axis_a_tready = 1'b0;
    apply_stimulus(5, 7, 3, acc);
    check_output("skew_accept", 32'(acc), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("skew_a_hold", 32'(bus.m_axis_a_tvalid), 32'd1);
      check_output("skew_b_valid", 32'(bus.m_axis_b_tvalid), 32'(i == 0));
      check_output("skew_op_ready", 32'(bus.op_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.m_axis_a_tready = 1'b1;
    drain();
    check_output("skew_result", last_res, to_f(12));

    $display("[TB] stray result");
    res_seen = 0;
    @(negedge clk);
    stray_req = 1;
    wait_cycles(4);
    check_output("stray_err", 32'(bus.err_unexpected), 32'd1);
    check_output("stray_no_res", 32'(bus.res_valid), 32'd0);
    wait_cycles(5);
    check_output("stray_sticky", 32'(bus.err_unexpected), 32'd1);
    check_output("stray_res_count", 32'(res_seen), 32'd0);

    $display("[TB] reset mid-stream");
    bus.res_ready = 1'b0;
    for (int i = 0; i < 3; i++) apply_stimulus(10 + i, 20, 3, acc);
    wait_cycles(10);
    for (int i = 0; i < 5; i++) apply_stimulus(100 + i, 3, 3, acc);
    aresetn = 1'b0;
    wait_cycles(1);
    check_reset_state();
    aresetn = 1'b1;
    wait_cycles(1);
    check_output("post_rst_op_ready", 32'(bus.op_ready), 32'd1);
    check_output("post_rst_inflight", 32'(bus.inflight), 32'd0);
    res_seen = 0;
    bus.res_ready = 1'b1;
    wait_cycles(20);
    check_output("post_rst_no_stale", 32'(res_seen), 32'd0);

    $display("[TB] random traffic");
    acc = 1;
    for (int c = 0; c < 400; c++) begin
      if (!bus.op_valid || acc) begin
        bus.op_valid = 1'($urandom_range(0, 1));
        bus.op_a     = to_f($urandom_range(0, 1 << 20));
        bus.op_b     = to_f($urandom_range(0, 1 << 20));
      end
      bus.m_axis_a_tready = ($urandom_range(0, 3) != 0);
      bus.m_axis_b_tready = ($urandom_range(0, 3) != 0);
      bus.res_ready       = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc = bus.op_valid && bus.op_ready;
      @(posedge clk); #1;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fadd_stream_master.md
Name: fadd_stream_master

Overview:
- Operand-side master and result-side slave for the AXI-Stream single-precision float adder core.
- Accepts operand pairs from an upstream requester and drives the adder's A and B slave channels independently.
- Collects adder results into an internal FIFO and presents them downstream.
- Credit-based issue guarantees the adder result channel is never back-pressured, so the adder pipeline never stalls on its output.

Parameters:
- DATA_W, 32, operand/result width (IEEE-754 single).
- RES_DEPTH, 16, result FIFO depth and maximum reserved operations (power of 2, >= 2).
- CNT_W, $clog2(RES_DEPTH)+1, width of the reservation and in-flight counters.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  synchronous active-low reset.
- op_valid  in  1  upstream operand pair valid.
- op_ready  out  1  operand pair accepted when op_valid && op_ready.
- op_a  in  DATA_W  operand A.
- op_b  in  DATA_W  operand B.
- m_axis_a_tvalid  out  1  to adder s_axis_a_tvalid.
- m_axis_a_tready  in  1  from adder s_axis_a_tready.
- m_axis_a_tdata  out  DATA_W  to adder s_axis_a_tdata.
- m_axis_b_tvalid / m_axis_b_tready / m_axis_b_tdata  out/in/out  1/1/DATA_W  same as A, for operand B.
- s_axis_result_tvalid  in  1  from adder m_axis_result_tvalid.
- s_axis_result_tready  out  1  to adder m_axis_result_tready.
- s_axis_result_tdata  in  DATA_W  from adder m_axis_result_tdata.
- res_valid  out  1  downstream result valid.
- res_ready  in  1  downstream accept.
- res_data  out  DATA_W  result, in issue order.
- inflight  out  CNT_W  operations issued to the adder with no result returned yet.
- err_unexpected  out  1  sticky; a result arrived while inflight == 0.

Behaviour:
- Reset (aresetn == 0 at a clock edge) drives the following to 0:
  - op_ready, m_axis_a_tvalid, m_axis_b_tvalid, m_axis_a_tdata, m_axis_b_tdata
  - s_axis_result_tready, res_valid, res_data
  - inflight, err_unexpected, and the reservation counter
  - FIFO pointers.
- Reset mid-operation discards all pending operands and buffered results. The adder shares aresetn and flushes with this block.
- Operand channels:
  - a_pend and b_pend are the registered tvalids.
  - On an op handshake, latch op_a/op_b into the tdata registers and set a_pend = b_pend = 1.
  - A is cleared on an A handshake and B on a B handshake, independently. Skewed acceptance is legal.
  - tvalid never drops and tdata never changes while pending and unaccepted (AXI-S rule).
- op_ready is high when aresetn is high, (!a_pend || m_axis_a_tready), (!b_pend || m_axis_b_tready), and reserved < RES_DEPTH.
  - Same-cycle re-issue is permitted when both channels complete that cycle.
  - Sustained throughput is 1 op/cycle with both treadys high.
- Reservation counter "reserved":
  - +1 on op handshake.
  - -1 on res handshake.
  - Both in the same cycle: unchanged.
  - Never exceeds RES_DEPTH.
- inflight:
  - +1 on op handshake.
  - -1 on an accepted result with inflight > 0.
  - Simultaneous events net out.
- s_axis_result_tready is 1 in every non-reset cycle. Credit guarantees FIFO space.
- Result with inflight == 0:
  - Data is dropped, the FIFO is unchanged, and err_unexpected is set.
  - err_unexpected clears only on reset.
- Result FIFO:
  - Registered output, no fall-through.
  - A result written at edge N is visible on res_valid/res_data after edge N+1 when the FIFO was empty.
  - Simultaneous write and read are supported at any occupancy.
  - Pointers wrap modulo RES_DEPTH.
  - res_data holds stable while res_valid && !res_ready.
- Latency, op handshake to res_valid (adder latency L, no stalls):
  - Min 1 cycle to the adder channel handshake.
  - Plus L cycles through the adder.
  - Plus 1 cycle through the FIFO.
- Ordering: results leave in op acceptance order. The adder is in-order.

Test Plan:
- Single op: op_a=0x3F800000, op_b=0x40000000 with both treadys high -> one A and one B handshake; res_data=0x40400000; inflight returns 1 -> 0; err_unexpected=0.
- Streaming: 32 back-to-back ops a=i, b=i (as float, i=1..32) with res_ready=1 -> op_ready stays high every cycle; results are 2i in order; no gaps after pipeline fill.
- Credit full: res_ready=0 while 20 ops are offered -> exactly 16 accepted; op_ready low from the 17th; reserved=16. Raising res_ready for one cycle -> exactly one more op accepted.
- Skewed channels: m_axis_a_tready held low 3 cycles and m_axis_b_tready high -> B handshakes at once; A tvalid/tdata stable for 3 cycles; op_ready low until the A handshake; result correct.
- Stray result: inject s_axis_result_tvalid with data 0x12345678 at inflight=0 -> err_unexpected=1 and stays 1; res_valid stays 0.
- Reset mid-stream: assert aresetn=0 for 1 cycle with 5 ops in flight and 3 results buffered -> all outputs 0 the next cycle; after release op_ready=1, inflight=0, and no stale result appears.
